wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: two 2-entry source queues (ALU, MEM) sharing one
// register-file write port. MEM wins ties unless the ALU head has waited MAX_WAIT cycles.
module wb_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        wb_sel,
    output logic [15:0] conflict_cnt
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    // queue entry layout: {rd[4:0], data[31:0]}
    logic [36:0] alu_q [2];
    logic [36:0] mem_q [2];
    logic        alu_wr_ptr, alu_rd_ptr;
    logic        mem_wr_ptr, mem_rd_ptr;
    logic [1:0]  alu_cnt, mem_cnt;
    logic [3:0]  alu_wait;

    logic        alu_head_v, mem_head_v;
    logic        alu_push, mem_push;
    logic        grant_alu, grant_mem;
    logic [36:0] alu_head, mem_head, grant_entry;

    always_comb begin
        alu_ready   = (alu_cnt < 2'd2) && !rst;
        mem_ready   = (mem_cnt < 2'd2) && !rst;
        alu_push    = alu_valid && alu_ready;
        mem_push    = mem_valid && mem_ready;
        alu_head_v  = (alu_cnt != 2'd0);
        mem_head_v  = (mem_cnt != 2'd0);
        alu_head    = alu_q[alu_rd_ptr];
        mem_head    = mem_q[mem_rd_ptr];
        grant_alu   = alu_head_v && (!mem_head_v || (alu_wait >= WAIT_LIMIT));
        grant_mem   = mem_head_v && !grant_alu;
        grant_entry = grant_alu ? alu_head : mem_head;
    end

    // storage carries no reset; occupancy is tracked by the counters alone
    always_ff @(posedge clk) begin
        if (alu_push) alu_q[alu_wr_ptr] <= {alu_rd, alu_result};
        if (mem_push) mem_q[mem_wr_ptr] <= {mem_rd, mem_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_wr_ptr <= 1'b0;
            alu_rd_ptr <= 1'b0;
            alu_cnt    <= 2'd0;
            mem_wr_ptr <= 1'b0;
            mem_rd_ptr <= 1'b0;
            mem_cnt    <= 2'd0;
        end else begin
            if (alu_push)  alu_wr_ptr <= !alu_wr_ptr;
            if (grant_alu) alu_rd_ptr <= !alu_rd_ptr;
            if (mem_push)  mem_wr_ptr <= !mem_wr_ptr;
            if (grant_mem) mem_rd_ptr <= !mem_rd_ptr;
            alu_cnt <= alu_cnt + {1'b0, alu_push} - {1'b0, grant_alu};
            mem_cnt <= mem_cnt + {1'b0, mem_push} - {1'b0, grant_mem};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_wait     <= 4'd0;
            conflict_cnt <= 16'd0;
            rf_we        <= 1'b0;
            rf_rd        <= 5'd0;
            rf_wdata     <= 32'd0;
            wb_sel       <= 1'b0;
        end else begin
            if (!alu_head_v || grant_alu)
                alu_wait <= 4'd0;
            else if (alu_wait < WAIT_LIMIT)
                alu_wait <= alu_wait + 4'd1;

            if (alu_head_v && mem_head_v && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;

            // x0 writes still drain the queue and update rd/data, but never strobe the RF
            if (grant_alu || grant_mem) begin
                rf_we    <= (grant_entry[36:32] != 5'd0);
                rf_rd    <= grant_entry[36:32];
                rf_wdata <= grant_entry[31:0];
                wb_sel   <= grant_mem;
            end else begin
                rf_we    <= 1'b0;
            end
        end
    end

endmodule
